shift_frame_rx: RTL and testbench

- Serial frame receiver that sits directly downstream of the 8-bit left shift register and consumes its serial output stream (MSB first, one bit per clock).
- Detects a start bit, then assembles WIDTH data bits, checks optional parity and validates the stop bit.
- Presents each good byte on a one-entry valid/ready output buffer.
- Reports parity errors, framing errors and overruns.

---
 rtl/shift_frame_rx.sv | 109 ++++++++++
 tb/tb_shift_frame_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, optional parity,
// stop bit. Good bytes go to a one-entry valid/ready buffer; errors pulse.
// Ports: C/CLR clock and async active-low reset, SI serial in (idle 1),
// DOUT/DVALID/DREADY output buffer, PERR/FERR error pulses, OVF sticky
// overrun flag, BUSY high whenever the receiver is not idle.
module shift_frame_rx #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             SI,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             PERR,
  output logic             FERR,
  output logic             OVF,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_bit;
  logic             par_ok;
  logic             commit;

  // XOR of data and received parity must equal 1 for odd, 0 for even
  assign par_ok = !PARITY_EN ||
                  ((^shreg ^ par_bit) == PARITY_ODD);
  assign commit = (state == S_STOP) && SI && par_ok;
  assign BUSY   = (state != S_IDLE);

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      state   <= S_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      par_bit <= 1'b0;
      PERR    <= 1'b0;
      FERR    <= 1'b0;
    end else begin
      PERR <= 1'b0;
      FERR <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!SI) begin
            state <= S_DATA;
            cnt   <= '0;
          end
        end
        S_DATA: begin
          shreg <= {shreg[WIDTH-2:0], SI};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= PARITY_EN ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          par_bit <= SI;
          state   <= S_STOP;
        end
        S_STOP: begin
          if (SI) begin
            PERR  <= !par_ok;
            state <= S_IDLE;
          end else begin
            // framing error wins; wait for line high before re-arming
            FERR  <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (SI)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
      OVF    <= 1'b0;
    end else if (commit) begin
      // a pop in the same cycle frees the slot for the new byte
      if (!DVALID || DREADY) begin
        DOUT   <= shreg;
        DVALID <= 1'b1;
      end else begin
        OVF <= 1'b1;
      end
    end else if (DVALID && DREADY) begin
      DVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_frame_rx.sv
// Directed bench for shift_frame_rx with default parameters.
// Each task drives one scenario and checks outputs #1 after posedge.
module tb_shift_frame_rx;

  logic       C = 1'b0;
  logic       CLR = 1'b0;
  logic       SI = 1'b1;
  logic       DREADY = 1'b0;
  logic [7:0] DOUT;
  logic       DVALID, PERR, FERR, OVF, BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  shift_frame_rx dut (
    .C(C), .CLR(CLR), .SI(SI),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY),
    .PERR(PERR), .FERR(FERR), .OVF(OVF), .BUSY(BUSY)
  );

  always #5 C = ~C;

  task automatic step(input logic b);
    SI = b;
    @(posedge C);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic stp, input logic pop_stop);
    step(1'b0);
    for (int i = 7; i >= 0; i--) step(d[i]);
    step(p);
    DREADY = pop_stop;
    step(stp);
    DREADY = 1'b0;
  endtask

  task automatic do_reset;
    SI = 1'b1;
    DREADY = 1'b0;
    CLR = 1'b0;
    #2;
    CLR = 1'b1;
    @(posedge C);
    #1;
  endtask

  task automatic test_reset;
    CLR = 1'b0;
    SI = 1'b1;
    @(posedge C);
    #1;
    n_checks++;
    if ({DOUT, DVALID, PERR, FERR, OVF, BUSY} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset: outs=%h required 0",
               {DOUT, DVALID, PERR, FERR, OVF, BUSY});
    end
    CLR = 1'b1;
    @(posedge C);
    #1;
  endtask

  task automatic test_good;
    logic [10:0] fr;
    do_reset();
    fr = {1'b0, 8'hA5, 1'b0, 1'b1};
    for (int i = 10; i >= 0; i--) begin
      step(fr[i]);
      n_checks++;
      if (BUSY !== (i != 0)) begin
        n_fail++;
        $display("FAIL good_busy edge %0d: got %b required %b",
                 11 - i, BUSY, i != 0);
      end
      n_checks++;
      if (DVALID !== (i == 0)) begin
        n_fail++;
        $display("FAIL good_dvalid edge %0d: got %b required %b",
                 11 - i, DVALID, i == 0);
      end
    end
    n_checks++;
    if (DOUT !== 8'hA5) begin
      n_fail++;
      $display("FAIL good_dout: got %h required a5", DOUT);
    end
    n_checks++;
    if ({PERR, FERR, OVF} !== 3'b000) begin
      n_fail++;
      $display("FAIL good_flags: got %b required 000", {PERR, FERR, OVF});
    end
    DREADY = 1'b1;
    step(1'b1);
    DREADY = 1'b0;
    n_checks++;
    if (DVALID !== 1'b0 || DOUT !== 8'hA5) begin
      n_fail++;
      $display("FAIL good_pop: dvalid=%b dout=%h required 0 a5",
               DVALID, DOUT);
    end
  endtask

  task automatic test_parity_error;
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (PERR !== 1'b1 || FERR !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_pulse: perr=%b ferr=%b required 1 0", PERR, FERR);
    end
    n_checks++;
    if (DVALID !== 1'b0 || DOUT !== 8'h00) begin
      n_fail++;
      $display("FAIL perr_nocommit: dvalid=%b dout=%h required 0 00",
               DVALID, DOUT);
    end
    step(1'b1);
    n_checks++;
    if (PERR !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_clear: got %b required 0", PERR);
    end
  endtask

  task automatic test_framing;
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (FERR !== 1'b1 || PERR !== 1'b0 || DVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_pulse: ferr=%b perr=%b dvalid=%b required 1 0 0",
               FERR, PERR, DVALID);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      n_checks++;
      if (FERR !== 1'b0 || BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL ferr_wait %0d: ferr=%b busy=%b required 0 1",
                 i, FERR, BUSY);
      end
    end
    step(1'b1);
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_idle: busy=%b required 0", BUSY);
    end
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (DVALID !== 1'b1 || DOUT !== 8'h3C || FERR !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_recover: dvalid=%b dout=%h ferr=%b required 1 3c 0",
               DVALID, DOUT, FERR);
    end
  endtask

  task automatic test_overrun;
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (DVALID !== 1'b1 || DOUT !== 8'h3C || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_first: dvalid=%b dout=%h ovf=%b required 1 3c 0",
               DVALID, DOUT, OVF);
    end
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (DVALID !== 1'b1 || DOUT !== 8'h3C || OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_second: dvalid=%b dout=%h ovf=%b required 1 3c 1",
               DVALID, DOUT, OVF);
    end
    DREADY = 1'b1;
    step(1'b1);
    DREADY = 1'b0;
    n_checks++;
    if (DVALID !== 1'b0 || OVF !== 1'b1 || DOUT !== 8'h3C) begin
      n_fail++;
      $display("FAIL ovf_pop: dvalid=%b ovf=%b dout=%h required 0 1 3c",
               DVALID, OVF, DOUT);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (DVALID !== 1'b1 || DOUT !== 8'hFF || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL popcommit: dvalid=%b dout=%h ovf=%b required 1 ff 0",
               DVALID, DOUT, OVF);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    n_checks++;
    if (BUSY !== 1'b1 || DVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: busy=%b dvalid=%b required 1 1", BUSY, DVALID);
    end
    SI = 1'b1;
    CLR = 1'b0;
    #2;
    n_checks++;
    if ({DOUT, DVALID, PERR, FERR, OVF, BUSY} !== 13'd0) begin
      n_fail++;
      $display("FAIL mid_reset: outs=%h required 0",
               {DOUT, DVALID, PERR, FERR, OVF, BUSY});
    end
    #3;
    CLR = 1'b1;
    @(posedge C);
    #1;
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (DVALID !== 1'b1 || DOUT !== 8'h81) begin
      n_fail++;
      $display("FAIL mid_after: dvalid=%b dout=%h required 1 81",
               DVALID, DOUT);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity_error();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
